// File: rtl/bt_cmd_parser_if.sv
// Byte-stream in / command-out bundle for bt_cmd_parser.
//   master : producer of rx_avail/rx_data and consumer of the cmd_* results
//   slave  : the parser itself
// Signals:
//   rx_avail     receiver byte available (level)
//   rx_data      receiver byte, stable while rx_avail=1
//   cmd_valid    1-cycle pulse, validated frame on cmd_*
//   cmd_code     CMD byte of last valid frame
//   cmd_len      LEN of last valid frame
//   cmd_payload  payload, byte0 in [7:0], unused bytes zero
//   frame_err    1-cycle pulse per dropped frame
//   err_cnt      saturating dropped-frame count
//   busy         parser is inside a frame
interface bt_cmd_parser_if #(
    parameter int MAX_LEN = 4
);
    logic                   rx_avail;
    logic [7:0]             rx_data;
    logic                   cmd_valid;
    logic [7:0]             cmd_code;
    logic [3:0]             cmd_len;
    logic [8*MAX_LEN-1:0]   cmd_payload;
    logic                   frame_err;
    logic [7:0]             err_cnt;
    logic                   busy;

    modport master (
        output rx_avail, rx_data,
        input  cmd_valid, cmd_code, cmd_len, cmd_payload, frame_err, err_cnt, busy
    );

    modport slave (
        input  rx_avail, rx_data,
        output cmd_valid, cmd_code, cmd_len, cmd_payload, frame_err, err_cnt, busy
    );
endinterface

// File: rtl/bt_cmd_parser.sv
// Framed command parser fed by the Bluetooth UART receiver.
// Frame: SYNC, CMD, LEN, PAYLOAD[LEN], CHK where CHK = XOR(CMD, LEN, payload).
// Ports:
//   clk_in   system clock
//   reset    asynchronous active-low reset
//   bus      bt_cmd_parser_if.slave (rx byte stream in, validated commands out)
// Bad checksum, oversize LEN or an inter-byte stall of TIMEOUT_CYC cycles drops
// the frame, pulses frame_err and bumps a saturating error counter.
module bt_cmd_parser #(
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 500000,
    parameter logic [7:0] SYNC_BYTE   = 8'hAA
) (
    input  logic           clk_in,
    input  logic           reset,
    bt_cmd_parser_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int IW = $clog2(MAX_LEN) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK
    } state_t;

    state_t                        r_state;
    logic                          r_avail_q;
    logic [TW-1:0]                 r_timer;
    logic [IW-1:0]                 r_idx;
    logic [7:0]                    r_chk;
    logic [7:0]                    r_cmd;
    logic [3:0]                    r_len;
    logic [MAX_LEN-1:0][7:0]       r_scratch;

    logic                          r_cmd_valid;
    logic [7:0]                    r_code;
    logic [3:0]                    r_len_o;
    logic [MAX_LEN-1:0][7:0]       r_payload;
    logic                          r_frame_err;
    logic [7:0]                    r_err_cnt;

    logic       w_stb;
    logic [7:0] w_byte;
    logic       w_timeout;
    logic       w_err;
    logic       w_last;

    // One accepted byte per rising edge of rx_avail, however long it is held.
    assign w_stb     = bus.rx_avail & ~r_avail_q;
    assign w_byte    = bus.rx_data;
    assign w_timeout = (r_state != S_IDLE) && (r_timer == TMAX);
    assign w_last    = (8'(r_idx) + 8'd1) == 8'(r_len);

    // A byte arriving on the timeout cycle takes precedence over the timeout.
    always_comb begin
        w_err = 1'b0;
        if (w_stb) begin
            w_err = ((r_state == S_LEN) && (w_byte > 8'(MAX_LEN))) ||
                    ((r_state == S_CHK) && (w_byte != r_chk));
        end else begin
            w_err = w_timeout;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_avail_q   <= 1'b0;
            r_timer     <= '0;
            r_idx       <= '0;
            r_chk       <= '0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_scratch   <= '0;
            r_cmd_valid <= 1'b0;
            r_code      <= '0;
            r_len_o     <= '0;
            r_payload   <= '0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_avail_q   <= bus.rx_avail;
            r_cmd_valid <= 1'b0;
            r_frame_err <= w_err;
            if (w_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;

            if (w_stb || (r_state == S_IDLE) || w_timeout)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            if (w_stb) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_byte == SYNC_BYTE)
                            r_state <= S_CMD;
                    end
                    S_CMD: begin
                        r_cmd   <= w_byte;
                        r_chk   <= w_byte;
                        r_state <= S_LEN;
                    end
                    S_LEN: begin
                        r_len     <= w_byte[3:0];
                        r_chk     <= r_chk ^ w_byte;
                        r_idx     <= '0;
                        r_scratch <= '0;
                        if (w_byte > 8'(MAX_LEN))
                            r_state <= S_IDLE;
                        else if (w_byte == 8'd0)
                            r_state <= S_CHK;
                        else
                            r_state <= S_DATA;
                    end
                    S_DATA: begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_idx == IW'(i))
                                r_scratch[i] <= w_byte;
                        end
                        r_chk <= r_chk ^ w_byte;
                        r_idx <= r_idx + IW'(1);
                        if (w_last)
                            r_state <= S_CHK;
                    end
                    S_CHK: begin
                        if (w_byte == r_chk) begin
                            r_code      <= r_cmd;
                            r_len_o     <= r_len;
                            r_payload   <= r_scratch;
                            r_cmd_valid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (w_timeout) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_code    = r_code;
    assign bus.cmd_len     = r_len_o;
    assign bus.cmd_payload = r_payload;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_bt_cmd_parser.sv
// Bench for bt_cmd_parser (MAX_LEN=4, TIMEOUT_CYC=100). A frame-level model
// collects accepted bytes in a queue and judges each frame as a whole; a
// negedge process compares every DUT output with the model each cycle.
module tb_bt_cmd_parser;
    localparam int ML = 4;
    localparam int TO = 100;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;
    always #5 clk_in = ~clk_in;

    bt_cmd_parser_if #(.MAX_LEN(ML)) bif ();

    bt_cmd_parser #(.MAX_LEN(ML), .TIMEOUT_CYC(TO), .SYNC_BYTE(8'hAA)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bif)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    logic        m_prev = 1'b0;
    int          m_timer = 0;
    logic        m_valid = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic [7:0]  m_code = 0, m_cnt = 0;
    logic [3:0]  m_len = 0;
    logic [31:0] m_payload = 0;

    task automatic m_drop();
        m_q.delete();
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic m_take(input logic [7:0] b);
        logic [7:0] x;
        if (m_q.size() == 0) begin
            if (b == 8'hAA) m_q.push_back(b);
        end else begin
            m_q.push_back(b);
            if (m_q.size() == 3 && m_q[2] > 8'(ML)) begin
                m_drop();
            end else if (m_q.size() >= 3 && m_q.size() == 4 + int'(m_q[2])) begin
                x = 8'h00;
                for (int i = 1; i < m_q.size() - 1; i++) x = x ^ m_q[i];
                if (x == m_q[m_q.size()-1]) begin
                    m_valid   = 1'b1;
                    m_code    = m_q[1];
                    m_len     = m_q[2][3:0];
                    m_payload = 32'h0;
                    for (int i = 0; i < int'(m_q[2]); i++) m_payload[8*i +: 8] = m_q[3+i];
                    m_q.delete();
                end else begin
                    m_drop();
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        if (!reset) begin
            m_q.delete();
            m_prev = 0; m_timer = 0; m_valid = 0; m_err = 0; m_busy = 0;
            m_code = 0; m_cnt = 0; m_len = 0; m_payload = 0;
        end else begin
            logic stb;
            stb = bif.rx_avail && !m_prev;
            m_prev = bif.rx_avail;
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (stb) begin
                m_timer = 0;
                m_take(bif.rx_data);
            end else if (m_q.size() > 0) begin
                m_timer++;
                if (m_timer >= TO) m_drop();
            end
            if (m_q.size() == 0) m_timer = 0;
            m_busy = (m_q.size() > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_in);
        if (reset) begin
            total++;
            if (bif.cmd_valid !== m_valid || bif.frame_err !== m_err || bif.busy !== m_busy ||
                bif.err_cnt !== m_cnt || bif.cmd_code !== m_code || bif.cmd_len !== m_len ||
                bif.cmd_payload !== m_payload) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got v=%b e=%b busy=%b cnt=%h code=%h len=%h pl=%h want v=%b e=%b busy=%b cnt=%h code=%h len=%h pl=%h",
                         $time, bif.cmd_valid, bif.frame_err, bif.busy, bif.err_cnt, bif.cmd_code,
                         bif.cmd_len, bif.cmd_payload, m_valid, m_err, m_busy, m_cnt, m_code, m_len, m_payload);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] fq[$];

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic sendb(input logic [7:0] b, input int hold, input int gap);
        bif.rx_data  = b;
        bif.rx_avail = 1'b1;
        tick(hold);
        bif.rx_avail = 1'b0;
        bif.rx_data  = 8'($urandom);
        tick(gap);
    endtask

    task automatic send_fq(input int hold, input int gap);
        foreach (fq[i]) sendb(fq[i], hold, gap);
        fq.delete();
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b0;
        tick(n);
        reset = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] cmd, ln, ck;
        int kind, k;
        bif.rx_avail = 1'b0;
        bif.rx_data  = 8'h00;
        reset = 1'b0;
        tick(3);
        lit("rst_valid", 32'(bif.cmd_valid), 0);
        lit("rst_err",   32'(bif.frame_err), 0);
        lit("rst_cnt",   32'(bif.err_cnt), 0);
        lit("rst_busy",  32'(bif.busy), 0);
        lit("rst_pl",    bif.cmd_payload, 0);
        reset = 1'b1;
        tick(3);

        // 1: good frame
        fq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_fq(16, 4);
        lit("s1_code", 32'(bif.cmd_code), 32'h01);
        lit("s1_len",  32'(bif.cmd_len), 2);
        lit("s1_pl",   bif.cmd_payload, 32'h0000_2010);
        lit("s1_cnt",  32'(bif.err_cnt), 0);

        // 2: bad checksum, outputs hold
        fq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_fq(16, 4);
        lit("s2_cnt",  32'(bif.err_cnt), 1);
        lit("s2_pl",   bif.cmd_payload, 32'h0000_2010);
        lit("s2_code", 32'(bif.cmd_code), 32'h01);

        // 3: oversize LEN
        fq = '{8'hAA, 8'h05, 8'h05};
        send_fq(16, 4);
        lit("s3_cnt",  32'(bif.err_cnt), 2);
        lit("s3_busy", 32'(bif.busy), 0);

        // 4: stall timeout, then a zero-length frame
        fq = '{8'hAA, 8'h07};
        send_fq(16, 4);
        tick(100);
        lit("s4_busy", 32'(bif.busy), 0);
        lit("s4_cnt",  32'(bif.err_cnt), 3);
        fq = '{8'hAA, 8'h07, 8'h00, 8'h07};
        send_fq(16, 4);
        lit("s4_len",  32'(bif.cmd_len), 0);
        lit("s4_pl",   bif.cmd_payload, 0);
        lit("s4_code", 32'(bif.cmd_code), 32'h07);

        // 5: long-held SYNC counts once; junk before SYNC ignored
        bif.rx_data  = 8'hAA;
        bif.rx_avail = 1'b1;
        tick(50);
        lit("s5_busy_hold", 32'(bif.busy), 1);
        tick(150);
        bif.rx_avail = 1'b0;
        tick(4);
        fq = '{8'h55, 8'hAA, 8'h03, 8'h01, 8'hFF, 8'hFD};
        send_fq(16, 4);
        lit("s5_pl",   bif.cmd_payload, 32'h0000_00FF);
        lit("s5_code", 32'(bif.cmd_code), 32'h03);

        // 6: reset mid-DATA, then good frame, then saturation
        fq = '{8'hAA, 8'h02, 8'h02, 8'h11};
        send_fq(16, 4);
        pulse_reset(3);
        tick(2);
        lit("s6_cnt_rst", 32'(bif.err_cnt), 0);
        fq = '{8'hAA, 8'h02, 8'h01, 8'h09, 8'h0A};
        send_fq(16, 4);
        lit("s6_pl",  bif.cmd_payload, 32'h0000_0009);
        lit("s6_len", 32'(bif.cmd_len), 1);
        lit("s6_cnt", 32'(bif.err_cnt), 0);
        repeat (256) begin
            fq = '{8'hAA, 8'h05, 8'h05};
            send_fq(2, 1);
        end
        lit("s6_sat", 32'(bif.err_cnt), 32'hFF);

        // randomized frames
        pulse_reset(2);
        tick(2);
        for (int f = 0; f < 250; f++) begin
            kind = $urandom_range(0, 7);
            cmd  = 8'($urandom);
            ln   = 8'($urandom_range(0, ML));
            fq = '{8'hAA, cmd, ln};
            ck = cmd ^ ln;
            for (int i = 0; i < int'(ln); i++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom);
                fq.push_back(d);
                ck = ck ^ d;
            end
            fq.push_back(ck);
            case (kind)
                2: fq[fq.size()-1] = ck ^ (8'h01 << $urandom_range(0, 7));
                3: begin
                    fq.delete();
                    fq = '{8'hAA, cmd, 8'($urandom_range(ML + 1, 255))};
                end
                4: begin
                    fq.delete();
                    k = $urandom_range(0, 254);
                    fq.push_back((k == 8'hAA) ? 8'h55 : 8'(k));
                end
                default: ;
            endcase
            if (kind == 5 || kind == 6) begin
                k = $urandom_range(1, fq.size() - 1);
                while (fq.size() > k) void'(fq.pop_back());
            end
            if (kind == 7) begin
                sendb(fq.pop_front(), $urandom_range(30, 60), 2);
            end
            foreach (fq[i]) sendb(fq[i], $urandom_range(1, 12), $urandom_range(1, 4));
            fq.delete();
            if (kind == 5) tick($urandom_range(90, 110));
            if (kind == 6) pulse_reset($urandom_range(1, 3));
        end
        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
